alu_op_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared ALU datapath. Two requesters compete for one ALU. The block grants one of them and drives the operand-select line of the 2:1 operand multiplexer. It launches the operation, waits the ALU's fixed latency, captures the result and returns it to the granted requester with a done pulse. It sits between the requester front-ends and the operand mux / ALU core.

---
 rtl/alu_op_arbiter_pkg.sv | 14 +
 rtl/alu_arb_pick.sv | 30 +++
 rtl/alu_op_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_op_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_op_arbiter_pkg.sv
// Shared FSM state encoding and operand-select codes for the ALU operand arbiter.
package alu_op_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_EXEC   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational winner select between requesters A and B.
// ALU_OP_ARBITER_RR_EN selects round-robin on ties; otherwise A has fixed priority.
module alu_arb_pick
  import alu_op_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
`ifdef ALU_OP_ARBITER_RR_EN
  input  logic last_sel,
`endif
  output logic pick_valid,
  output logic pick_sel
);

  always_comb begin
    pick_valid = req_a | req_b;
    pick_sel   = SEL_A;
    if (req_a && req_b) begin
`ifdef ALU_OP_ARBITER_RR_EN
      // The side that did not win last time takes the tie.
      pick_sel = (last_sel == SEL_B) ? SEL_A : SEL_B;
`else
      pick_sel = SEL_A;
`endif
    end else if (req_b) begin
      pick_sel = SEL_B;
    end
  end

endmodule

// File: rtl/alu_op_arbiter.sv
// Two-port arbiter/sequencer for the shared ALU: grant, launch, wait latency, return result.
// Optional macro ALU_OP_ARBITER_RR_EN enables round-robin tie breaking.
module alu_op_arbiter
  import alu_op_arbiter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             alu_sel,
  output logic             alu_go,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] result_o,
  output logic             done_a,
  output logic             done_b,
  output logic             busy
);

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       sel_nx, go_nx, ack_a_nx, ack_b_nx, done_a_nx, done_b_nx;
  logic       capture;
  logic       pick_valid, pick_sel;

`ifdef ALU_OP_ARBITER_RR_EN
  logic last_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sel <= SEL_B;
    end else if (state == ST_IDLE && pick_valid) begin
      last_sel <= pick_sel;
    end
  end

  alu_arb_pick u_pick (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_sel   (last_sel),
    .pick_valid (pick_valid),
    .pick_sel   (pick_sel)
  );
`else
  alu_arb_pick u_pick (
    .req_a      (req_a),
    .req_b      (req_b),
    .pick_valid (pick_valid),
    .pick_sel   (pick_sel)
  );
`endif

  // The counter is loaded on entry to LAUNCH, so LAUNCH already counts as the
  // first latency cycle and done lands ALU_LAT cycles after alu_go.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    sel_nx    = alu_sel;
    go_nx     = 1'b0;
    ack_a_nx  = 1'b0;
    ack_b_nx  = 1'b0;
    done_a_nx = 1'b0;
    done_b_nx = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nx = ST_LAUNCH;
          sel_nx   = pick_sel;
          go_nx    = 1'b1;
          ack_a_nx = (pick_sel == SEL_A);
          ack_b_nx = (pick_sel == SEL_B);
          cnt_nx   = CNT_LOAD;
        end
      end
      ST_LAUNCH, ST_EXEC: begin
        if (cnt == 4'd0) begin
          state_nx  = ST_DONE;
          capture   = 1'b1;
          done_a_nx = (alu_sel == SEL_A);
          done_b_nx = (alu_sel == SEL_B);
        end else begin
          state_nx = ST_EXEC;
          cnt_nx   = cnt - 4'd1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      alu_sel  <= SEL_A;
      alu_go   <= 1'b0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      busy     <= 1'b0;
      result_o <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      alu_sel <= sel_nx;
      alu_go  <= go_nx;
      ack_a   <= ack_a_nx;
      ack_b   <= ack_b_nx;
      done_a  <= done_a_nx;
      done_b  <= done_b_nx;
      busy    <= (state_nx != ST_IDLE);
      if (capture) begin
        result_o <= alu_y;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Bench for alu_op_arbiter: cycle tables at ALU_LAT=1 and ALU_LAT=3, reset abort, tie order.
`timescale 1ns/1ps
module tb_alu_op_arbiter;

  localparam bit L = 1'b0;
  localparam bit H = 1'b1;

  typedef struct {
    logic       ra, rb;
    logic [7:0] y;
    logic       ea, eb, esel, ego;
    logic [7:0] eres;
    logic       eda, edb, ebusy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       r1_a = 1'b0, r1_b = 1'b0, a1_a, a1_b, s1, g1, d1_a, d1_b, b1;
  logic [7:0] y1 = 8'h00, res1;
  logic       r3_a = 1'b0, r3_b = 1'b0, a3_a, a3_b, s3, g3, d3_a, d3_b, b3;
  logic [7:0] y3 = 8'h00, res3;
  logic [14:0] o1, o3;

  assign o1 = {a1_a, a1_b, s1, g1, res1, d1_a, d1_b, b1};
  assign o3 = {a3_a, a3_b, s3, g3, res3, d3_a, d3_b, b3};

  alu_op_arbiter #(.WIDTH(8), .ALU_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_a(r1_a), .req_b(r1_b), .ack_a(a1_a), .ack_b(a1_b),
    .alu_sel(s1), .alu_go(g1), .alu_y(y1), .result_o(res1), .done_a(d1_a), .done_b(d1_b),
    .busy(b1)
  );

  alu_op_arbiter #(.WIDTH(8), .ALU_LAT(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .req_a(r3_a), .req_b(r3_b), .ack_a(a3_a), .ack_b(a3_b),
    .alu_sel(s3), .alu_go(g3), .alu_y(y3), .result_o(res3), .done_a(d3_a), .done_b(d3_b),
    .busy(b3)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];
  vec_t t1[12];
  vec_t t3[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ra, input logic rb, input logic [7:0] y,
                              input logic ea, input logic eb, input logic sel, input logic go,
                              input logic [7:0] res, input logic da, input logic db,
                              input logic bsy);
    vec_t v;
    v.ra = ra; v.rb = rb; v.y = y;
    v.ea = ea; v.eb = eb; v.esel = sel; v.ego = go;
    v.eres = res; v.eda = da; v.edb = db; v.ebusy = bsy;
    return v;
  endfunction

  // Drive one row, clock once, compare outputs one tick after the edge.
  task automatic step(input int which, input vec_t v, input string tag);
    logic [14:0] got, exp;
    if (which == 1) begin
      r1_a = v.ra; r1_b = v.rb; y1 = v.y;
    end else begin
      r3_a = v.ra; r3_b = v.rb; y3 = v.y;
    end
    @(posedge clk); #1;
    got = (which == 1) ? o1 : o3;
    exp = {v.ea, v.eb, v.esel, v.ego, v.eres, v.eda, v.edb, v.ebusy};
    chk({tag, "_ack_a"},  32'(got[14]),   32'(exp[14]));
    chk({tag, "_ack_b"},  32'(got[13]),   32'(exp[13]));
    chk({tag, "_sel"},    32'(got[12]),   32'(exp[12]));
    chk({tag, "_go"},     32'(got[11]),   32'(exp[11]));
    chk({tag, "_result"}, 32'(got[10:3]), 32'(exp[10:3]));
    chk({tag, "_done_a"}, 32'(got[2]),    32'(exp[2]));
    chk({tag, "_done_b"}, 32'(got[1]),    32'(exp[1]));
    chk({tag, "_busy"},   32'(got[0]),    32'(exp[0]));
  endtask

  initial begin
    // ALU_LAT=1: A alone, B alone, tie, B waiting through A's DONE.
    t1[0]  = mk(H, L, 8'h00, H, L, L, H, 8'h00, L, L, H);
    t1[1]  = mk(L, L, 8'h3C, L, L, L, L, 8'h3C, H, L, H);
    t1[2]  = mk(L, L, 8'h00, L, L, L, L, 8'h3C, L, L, L);
    t1[3]  = mk(L, H, 8'h00, L, H, H, H, 8'h3C, L, L, H);
    t1[4]  = mk(L, L, 8'h5A, L, L, H, L, 8'h5A, L, H, H);
    t1[5]  = mk(L, L, 8'h00, L, L, H, L, 8'h5A, L, L, L);
    t1[6]  = mk(H, H, 8'h00, H, L, L, H, 8'h5A, L, L, H);
    t1[7]  = mk(L, H, 8'h77, L, L, L, L, 8'h77, H, L, H);
    t1[8]  = mk(L, H, 8'h00, L, L, L, L, 8'h77, L, L, L);
    t1[9]  = mk(L, H, 8'h00, L, H, H, H, 8'h77, L, L, H);
    t1[10] = mk(L, L, 8'hE1, L, L, H, L, 8'hE1, L, H, H);
    t1[11] = mk(L, L, 8'h00, L, L, H, L, 8'hE1, L, L, L);
    // ALU_LAT=3: B alone, then req_b rising during A's EXEC. alu_y is valid only at the capture edge.
    t3[0]  = mk(L, H, 8'h00, L, H, H, H, 8'h00, L, L, H);
    t3[1]  = mk(L, L, 8'h00, L, L, H, L, 8'h00, L, L, H);
    t3[2]  = mk(L, L, 8'h00, L, L, H, L, 8'h00, L, L, H);
    t3[3]  = mk(L, L, 8'hA5, L, L, H, L, 8'hA5, L, H, H);
    t3[4]  = mk(L, L, 8'h00, L, L, H, L, 8'hA5, L, L, L);
    t3[5]  = mk(H, L, 8'h00, H, L, L, H, 8'hA5, L, L, H);
    t3[6]  = mk(L, L, 8'h00, L, L, L, L, 8'hA5, L, L, H);
    t3[7]  = mk(L, H, 8'h00, L, L, L, L, 8'hA5, L, L, H);
    t3[8]  = mk(L, H, 8'hC3, L, L, L, L, 8'hC3, H, L, H);
    t3[9]  = mk(L, H, 8'h00, L, L, L, L, 8'hC3, L, L, L);
    t3[10] = mk(L, H, 8'h00, L, H, H, H, 8'hC3, L, L, H);
    t3[11] = mk(L, L, 8'h00, L, L, H, L, 8'hC3, L, L, H);
    t3[12] = mk(L, L, 8'h00, L, L, H, L, 8'hC3, L, L, H);
    t3[13] = mk(L, L, 8'h96, L, L, H, L, 8'h96, L, H, H);
    t3[14] = mk(L, L, 8'h00, L, L, H, L, 8'h96, L, L, L);

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_l1_outputs", 32'(o1), 32'd0);
    chk("rst_l3_outputs", 32'(o3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) step(1, t1[i], $sformatf("l1_v%0d", i));
    for (int i = 0; i < 15; i++) step(3, t3[i], $sformatf("l3_v%0d", i));

    // Reset one cycle after alu_go aborts the operation.
    r3_a = 1'b1; y3 = 8'h4B;
    @(posedge clk); #1;
    chk("rmid_go", 32'(g3), 32'd1);
    chk("rmid_ack_a", 32'(a3_a), 32'd1);
    r3_a = 1'b0;
    @(posedge clk); #1;
    chk("rmid_busy_pre", 32'(b3), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmid_busy", 32'(b3), 32'd0);
    chk("rmid_result_l3", 32'(res3), 32'd0);
    chk("rmid_result_l1", 32'(res1), 32'd0);
    chk("rmid_sel", 32'(s3), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rmid_no_done_%0d", c), 32'({d3_a, d3_b, b3}), 32'd0);
    end

    // Continuous tie on ALU_LAT=1 after reset.
`ifdef ALU_OP_ARBITER_RR_EN
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
`else
    exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
`endif
    r1_a = 1'b1; r1_b = 1'b1; y1 = 8'h11;
    begin
      int grants;
      int last_c;
      logic [0:0] e;
      grants = 0;
      last_c = 0;
      for (int c = 1; c <= 40 && grants < 4; c++) begin
        @(posedge clk); #1;
        chk("tie_ack_excl", 32'(a1_a & a1_b), 32'd0);
        chk("tie_done_excl", 32'(d1_a & d1_b), 32'd0);
        if (a1_a | a1_b) begin
          e = exp_q.pop_front();
          chk($sformatf("tie_grant%0d_is_b", grants), 32'(a1_b), 32'(e));
          if (grants > 0) chk($sformatf("tie_spacing%0d", grants), 32'(c - last_c), 32'd3);
          last_c = c;
          grants++;
        end
      end
      chk("tie_grant_count", 32'(grants), 32'd4);
    end
    r1_a = 1'b0; r1_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, expected finish before 100000ns");
    $fatal(1);
  end

endmodule
